// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
// Purpose: bundles the two requester ports and the single-port RAM bus that
//          the round-robin RAM arbiter sits between.
// Signals:
//   req0/req1        access request, held until the matching ack
//   we0/we1          write (1) / read (0) for that request
//   addr0/addr1      request address, Bits wide
//   wdata0/wdata1    8-bit write data
//   ack0/ack1        one-cycle completion pulse
//   rdata0/rdata1    8-bit read data, held until the port's next read
//   ramWe, ramAddr, ramDataIn   RAM write enable, address, write data
//   ramDataOut       RAM read data (combinational from ramAddr)
//   busy             arbiter not idle
// Modports:
//   slave  - arbiter view
//   master - environment view (requesters plus the RAM itself)
// ---------------------------------------------------------------------------
interface ram_arbiter_if #(
  parameter int Bits = 16
);
  logic            req0;
  logic            we0;
  logic [Bits-1:0] addr0;
  logic [7:0]      wdata0;
  logic            ack0;
  logic [7:0]      rdata0;

  logic            req1;
  logic            we1;
  logic [Bits-1:0] addr1;
  logic [7:0]      wdata1;
  logic            ack1;
  logic [7:0]      rdata1;

  logic            ramWe;
  logic [Bits-1:0] ramAddr;
  logic [7:0]      ramDataIn;
  logic [7:0]      ramDataOut;
  logic            busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ramDataOut,
    output ack0, rdata0, ack1, rdata1,
    output ramWe, ramAddr, ramDataIn, busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ramDataOut,
    input  ack0, rdata0, ack1, rdata1,
    input  ramWe, ramAddr, ramDataIn, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Purpose: shares one single-port RAM between two requesters. Each access
//          takes IDLE -> ACCESS -> DONE (3 cycles). Ties are broken
//          round-robin against the last granted port, so under continuous
//          load the grants strictly alternate.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    ram_arbiter_if.slave: requester ports 0/1 and the RAM bus
// ---------------------------------------------------------------------------
module ram_arbiter #(
  parameter int Bits = 16
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            lastGrant_q, lastGrant_d;
  logic            we_q, we_d;
  logic [Bits-1:0] addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata0_q, rdata0_d;
  logic [7:0]      rdata1_q, rdata1_d;
  logic            anyReq;
  logic            winner;

  // Port 1 wins alone or on a tie when port 0 had the previous grant.
  assign anyReq = bus.req0 | bus.req1;
  assign winner = (bus.req0 & bus.req1) ? ~lastGrant_q : bus.req1;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (anyReq) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: the request is latched at grant so later
  // requester changes cannot disturb the access in flight.
  always_comb begin
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    if (state_q == IDLE && anyReq) begin
      grant_d     = winner;
      lastGrant_d = winner;
      we_d        = winner ? bus.we1    : bus.we0;
      addr_d      = winner ? bus.addr1  : bus.addr0;
      wdata_d     = winner ? bus.wdata1 : bus.wdata0;
    end
    if (state_q == ACCESS && !we_q) begin
      if (grant_q) begin
        rdata1_d = bus.ramDataOut;
      end else begin
        rdata0_d = bus.ramDataOut;
      end
    end
  end

  // Datapath registers; lastGrant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Outputs: ramWe is gated by state so an async reset drops it at once.
  always_comb begin
    bus.ramWe     = (state_q == ACCESS) && we_q;
    bus.ramAddr   = addr_q;
    bus.ramDataIn = wdata_q;
    bus.ack0      = (state_q == DONE) && !grant_q;
    bus.ack1      = (state_q == DONE) && grant_q;
    bus.rdata0    = rdata0_q;
    bus.rdata1    = rdata1_q;
    bus.busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Purpose: self-checking bench for ram_arbiter. A behavioural RAM answers
//          the arbiter; every ack pops an expected {port, rdata} record from
//          a scoreboard queue that was filled when the request was driven.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;
  localparam int Bits = 16;

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  expRdata;
  } vec_t;

  typedef struct {
    bit         port;
    logic [7:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  exp_t       sbQ[$];
  logic [7:0] commRd[2];
  exp_t       monE;
  logic       monP;

  ram_arbiter_if #(.Bits(Bits)) bus();

  ram_arbiter #(.Bits(Bits)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: unwritten locations read back a fixed address pattern.
  logic [7:0] mem     [0:65535];
  bit         written [0:65535];

  function automatic logic [7:0] initVal(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hC3;
  endfunction

  function automatic logic [7:0] ramPeek(input logic [15:0] a);
    return written[a] ? mem[a] : initVal(a);
  endfunction

  assign bus.ramDataOut = ramPeek(bus.ramAddr);

  always @(posedge clk) begin
    if (bus.ramWe) begin
      mem[bus.ramAddr]     <= bus.ramDataIn;
      written[bus.ramAddr] <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every ack must match the oldest outstanding request.
  always @(negedge clk) begin
    if (reset === 1'b1 && (bus.ack0 || bus.ack1)) begin
      checkOutput("acks_exclusive", {31'b0, bus.ack0 & bus.ack1}, 0);
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ack: ack0=%0b ack1=%0b, expected no ack",
                 bus.ack0, bus.ack1);
      end else begin
        monE = sbQ.pop_front();
        monP = bus.ack1;
        checkOutput("ack_port", {31'b0, monP}, {31'b0, monE.port});
        if (monP) begin
          checkOutput("rdata1_on_ack", {24'b0, bus.rdata1}, {24'b0, monE.rd});
          checkOutput("rdata0_unchanged", {24'b0, bus.rdata0}, {24'b0, commRd[0]});
        end else begin
          checkOutput("rdata0_on_ack", {24'b0, bus.rdata0}, {24'b0, monE.rd});
          checkOutput("rdata1_unchanged", {24'b0, bus.rdata1}, {24'b0, commRd[1]});
        end
        commRd[monP] = monE.rd;
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    reset    = 1'b0;
    sbQ.delete();
    commRd[0] = 8'h00;
    commRd[1] = 8'h00;
    #1;
    checkOutput("rst_ramWe", {31'b0, bus.ramWe}, 0);
    checkOutput("rst_busy", {31'b0, bus.busy}, 0);
    checkOutput("rst_ack0", {31'b0, bus.ack0}, 0);
    checkOutput("rst_ack1", {31'b0, bus.ack1}, 0);
    checkOutput("rst_ramAddr", {16'b0, bus.ramAddr}, 0);
    checkOutput("rst_ramDataIn", {24'b0, bus.ramDataIn}, 0);
    checkOutput("rst_rdata0", {24'b0, bus.rdata0}, 0);
    checkOutput("rst_rdata1", {24'b0, bus.rdata1}, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One isolated access on one port, with latency and RAM-bus checks.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   lat;
    bit   seen;
    @(negedge clk);
    if (v.port) begin
      bus.req1 = 1'b1; bus.we1 = v.we; bus.addr1 = v.addr; bus.wdata1 = v.wdata;
    end else begin
      bus.req0 = 1'b1; bus.we0 = v.we; bus.addr0 = v.addr; bus.wdata0 = v.wdata;
    end
    e.port = v.port;
    e.rd   = v.expRdata;
    sbQ.push_back(e);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checkOutput("busy_access", {31'b0, bus.busy}, 1);
        checkOutput("ramWe_access", {31'b0, bus.ramWe}, {31'b0, v.we});
        checkOutput("ramAddr_access", {16'b0, bus.ramAddr}, {16'b0, v.addr});
        if (v.we) checkOutput("ramDataIn_access", {24'b0, bus.ramDataIn}, {24'b0, v.wdata});
      end
      if ((v.port && bus.ack1) || (!v.port && bus.ack0)) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    checkOutput("ack_latency", lat, 2);
    checkOutput("ramWe_done", {31'b0, bus.ramWe}, 0);
    if (v.port) bus.req1 = 1'b0;
    else        bus.req0 = 1'b0;
  endtask

  function automatic exp_t mkExp(input bit p, input logic [7:0] rd);
    exp_t e;
    e.port = p;
    e.rd   = rd;
    return e;
  endfunction

  vec_t vecs[10];
  int   t0, t1, nAcks;
  bit   order[$];
  bit   seen;

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

    // Unwritten locations read as addr[7:0]^addr[15:8]^C3.
    vecs[0] = '{0, 1, 16'h1234, 8'h5A, 8'h00};
    vecs[1] = '{0, 0, 16'h1234, 8'h00, 8'h5A};
    vecs[2] = '{1, 0, 16'h1234, 8'h00, 8'h5A};
    vecs[3] = '{1, 1, 16'h0001, 8'h33, 8'h5A};
    vecs[4] = '{0, 0, 16'h0001, 8'h00, 8'h33};
    vecs[5] = '{1, 0, 16'h0002, 8'h00, 8'hC1};
    vecs[6] = '{0, 1, 16'h8000, 8'hA5, 8'h33};
    vecs[7] = '{0, 0, 16'h8000, 8'h00, 8'hA5};
    vecs[8] = '{1, 0, 16'h8000, 8'h00, 8'hA5};
    vecs[9] = '{1, 0, 16'h0001, 8'h00, 8'h33};

    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Simultaneous requests after reset: port 0 first, port 1 three cycles on.
    doReset();
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0020;
    sbQ.push_back(mkExp(0, 8'hD3));
    sbQ.push_back(mkExp(1, 8'hE3));
    t0 = -1;
    t1 = -1;
    for (int i = 1; i <= 20 && (t0 < 0 || t1 < 0); i++) begin
      @(negedge clk);
      if (bus.ack0) begin t0 = i; bus.req0 = 1'b0; end
      if (bus.ack1) begin t1 = i; bus.req1 = 1'b0; end
    end
    checkOutput("tie_ack0_time", t0, 2);
    checkOutput("tie_ack1_time", t1, 5);

    // Continuous load on both ports: six accesses alternating 0,1,0,1,0,1.
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0100;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0200;
    for (int k = 0; k < 3; k++) begin
      sbQ.push_back(mkExp(0, 8'hC2));
      sbQ.push_back(mkExp(1, 8'hC1));
    end
    nAcks = 0;
    order.delete();
    for (int i = 1; i <= 40 && nAcks < 6; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) begin
        order.push_back(bus.ack1);
        nAcks++;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    checkOutput("rr_ack_count", nAcks, 6);
    for (int k = 0; k < order.size(); k++)
      checkOutput("rr_order", {31'b0, order[k]}, k % 2);

    // Port 1 write whose request is withdrawn and altered during ACCESS.
    @(negedge clk);
    @(negedge clk);
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'hFFFF; bus.wdata1 = 8'hFF;
    sbQ.push_back(mkExp(1, 8'hC1));
    @(negedge clk);
    checkOutput("drop_ramAddr", {16'b0, bus.ramAddr}, 32'hFFFF);
    checkOutput("drop_ramWe", {31'b0, bus.ramWe}, 1);
    bus.req1 = 1'b0; bus.addr1 = 16'h0000; bus.wdata1 = 8'h00;
    seen = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.ack1) seen = 1'b1;
    end
    checkOutput("drop_ack1_seen", {31'b0, seen}, 1);
    checkOutput("drop_mem_ffff", {24'b0, ramPeek(16'hFFFF)}, 32'hFF);
    checkOutput("drop_mem_0000", {24'b0, ramPeek(16'h0000)}, 32'hC3);

    // Reset asserted in the middle of a port 0 write aborts it.
    @(negedge clk);
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0042; bus.wdata0 = 8'hAA;
    @(negedge clk);
    checkOutput("abort_ramWe_before", {31'b0, bus.ramWe}, 1);
    bus.req0 = 1'b0;
    #1 reset = 1'b0;
    sbQ.delete();
    commRd[0] = 8'h00;
    commRd[1] = 8'h00;
    #1;
    checkOutput("abort_ramWe", {31'b0, bus.ramWe}, 0);
    checkOutput("abort_busy", {31'b0, bus.busy}, 0);
    checkOutput("abort_ack0", {31'b0, bus.ack0}, 0);
    checkOutput("abort_ramAddr", {16'b0, bus.ramAddr}, 0);
    checkOutput("abort_ramDataIn", {24'b0, bus.ramDataIn}, 0);
    checkOutput("abort_rdata0", {24'b0, bus.rdata0}, 0);
    checkOutput("abort_rdata1", {24'b0, bus.rdata1}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("abort_idle_busy", {31'b0, bus.busy}, 0);
    checkOutput("abort_mem_0042", {24'b0, ramPeek(16'h0042)}, 32'h81);

    checkOutput("sb_empty", sbQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: Bits, default 16, RAM address width (64 KB at default).
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req0  input  1  port 0 access request; held high until ack0.
REQ-005 we0  input  1  port 0 write (1) / read (0); valid while req0 high.
REQ-006 addr0  input  Bits  port 0 address; valid while req0 high.
REQ-007 wdata0  input  8  port 0 write data; valid while req0 high.
REQ-008 ack0  output  1  port 0 completion pulse, one cycle.
REQ-009 rdata0  output  8  port 0 read data; valid from ack0 cycle until port 0's next completed read.
REQ-010 req1, we1, addr1, wdata1, ack1, rdata1: same directions, widths and meaning as REQ-004..009, for port 1.
REQ-011 ramWe  output  1  RAM write enable.
REQ-012 ramAddr  output  Bits  RAM address.
REQ-013 ramDataIn  output  8  RAM write data.
REQ-014 ramDataOut  input  8  RAM read data; combinational from ramAddr, valid same cycle.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 Arbiter SHALL implement three states: IDLE, ACCESS, DONE; DONE->IDLE unconditionally.
REQ-017 IDLE: if neither req sampled high at the clock edge, SHALL stay IDLE.
REQ-018 IDLE: if exactly one req high, SHALL grant that port and enter ACCESS.
REQ-019 IDLE: if both req high, SHALL grant the port not equal to lastGrant (round-robin) and enter ACCESS.
REQ-020 On grant SHALL register the winner's we, addr and wdata into ramWe/ramAddr/ramDataIn, and set lastGrant to the winner.
REQ-021 ramWe SHALL be high only in ACCESS with registered we=1; zero in all other states.
REQ-022 ramAddr and ramDataIn SHALL hold their last granted values outside ACCESS.
REQ-023 At the edge ending ACCESS, for a read the arbiter SHALL capture ramDataOut into the granted port's rdata; rdata of the other port SHALL be unchanged.
REQ-024 Writes SHALL leave both rdata registers unchanged.
REQ-025 ackN SHALL be high for exactly the DONE cycle of a port-N access; never both acks high together.
REQ-026 Latency: req sampled in IDLE at edge E -> ACCESS in cycle E+1 -> ack in cycle E+2; one access per 3 cycles max.
REQ-027 Once granted, the access SHALL complete and ack SHALL be issued even if req drops during ACCESS.
REQ-028 Requester changes to we/addr/wdata after grant SHALL NOT affect the granted access.
REQ-029 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-030 Under continuous requests from both ports, grants SHALL strictly alternate; neither port waits more than one access.

Reset
REQ-031 reset low SHALL immediately force: state IDLE, ramWe 0, ack0/ack1 0, busy 0, ramAddr 0, ramDataIn 0, rdata0/rdata1 0, lastGrant 1 (port 0 wins first tie).
REQ-032 reset asserted during ACCESS SHALL abort the access: no ack, no rdata update; ramWe drops without waiting for clk.
REQ-033 After reset release, first arbitration SHALL occur at the first rising edge with reset high.

Verification
REQ-034 Port 0 write 0x5A to 0x1234, then port 0 read 0x1234 -> ramWe high one cycle with ramAddr 0x1234; ack0 at E+2 each time; rdata0=0x5A.
REQ-035 Both ports request at the same edge after reset (port 0 read 0x0010, port 1 read 0x0020) -> port 0 served first, ack0; then port 1, ack1 three cycles later; rdata1 updates, rdata0 unchanged on port 1's access.
REQ-036 Both ports hold req continuously for 6 accesses -> ack sequence 0,1,0,1,0,1; never ack0 and ack1 together.
REQ-037 Port 1 write 0xFF to 0xFFFF, drop req1 and change addr1 to 0x0000 in the ACCESS cycle -> write still lands at 0xFFFF, ack1 still pulses.
REQ-038 Assert reset mid-ACCESS of a port 0 write -> ramWe 0 immediately, no ack0, memory unchanged when no clk edge occurred with ramWe high; all outputs at reset values.
